// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver:
// segment bit positions, the active-high hex glyph table and the scan FSM states.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Glyphs 0-9, A, b, C, d, E, F; bit SEG_A is the LSB, a set bit lights the segment.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to 7-segment pattern decoder with selectable
// output polarity.
module seg7_hex_lut
    import seg7_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_ACTIVE_LOW ? ~HEX_SEG[nibble_i] : HEX_SEG[nibble_i];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NUM_DIGITS 7-segment driver: shadow/display double buffer
// swapped at frame boundaries, anti-ghosting blank gap and leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam scan_state_e      ENTRY_ST   = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    scan_state_e            state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   frame_boundary;

    logic [NUM_DIGITS-1:0][3:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0][3:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]      disp_dp_q, disp_dp_d;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fs_q, fs_d;

    logic                  showing;
    logic                  all_zero;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [6:0]            lut_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            fs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            fs_q         <= fs_d;
        end
    end

    // Scan sequencer; every transition into digit 0 is a frame boundary.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        frame_boundary = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d        = ENTRY_ST;
                    idx_d          = '0;
                    cnt_d          = '0;
                    frame_boundary = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ENTRY_ST;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d          = '0;
                            frame_boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A load coinciding with a boundary goes straight through to the display copy.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
        end
        if (frame_boundary) begin
            disp_val_d = shadow_val_d;
            disp_dp_d  = shadow_dp_d;
        end
    end

    always_comb begin
        all_zero  = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero & (disp_val_q[i] == 4'd0);
            lead_zero[i] = all_zero;
        end
        lead_zero[0] = 1'b0;
    end

    always_comb begin
        an_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_onehot[i] = (idx_q == IDX_W'(i));
        end
    end

    seg7_hex_lut #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_lut (
        .nibble_i(disp_val_q[idx_q]),
        .seg_o   (lut_seg)
    );

    // Blanked leading zeros keep their anode and dp so the digit position stays lit.
    always_comb begin
        showing = enable && (state_q == SHOW);
        an_d    = showing ? (an_onehot ^ AN_OFF) : AN_OFF;
        seg_d   = (showing && !(lz_suppress && lead_zero[idx_q])) ? lut_seg : SEG_OFF;
        dp_d    = (showing && disp_dp_q[idx_q]) ? ~DP_OFF : DP_OFF;
        fs_d    = showing && (idx_q == '0) && (cnt_q == '0);
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: frame-position reference model
// compared every cycle, plus directed literal checks of the key scenarios.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BC    = 1;
    localparam int SLOT  = RD + BC;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic        lz_suppress = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int n_checks = 0;
    int n_errors = 0;

    seg7_scan_driver #(
        .NUM_DIGITS(ND),
        .REFRESH_DIV(RD),
        .BLANK_CYCLES(BC),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .load(load),
        .value(value),
        .dp_in(dp_in),
        .lz_suppress(lz_suppress),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_start(frame_start)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // reference glyphs, active-high, g..a
    logic [6:0] hex_g2a [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // model: m_sp is the scan position within the frame, -1 while idle
    int          m_sp = -1;
    int          m_slot, m_off;
    logic [15:0] m_shadow, m_disp;
    logic [3:0]  m_shadow_dp, m_disp_dp;
    logic [3:0]  m_nib;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fs;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        exp_fs  = 1'b0;
        if (rst) begin
            m_sp        = -1;
            m_shadow    = 16'h0;
            m_disp      = 16'h0;
            m_shadow_dp = 4'h0;
            m_disp_dp   = 4'h0;
            model_ok    = 1'b1;
        end else begin
            if (enable && m_sp >= 0) begin
                m_slot = m_sp / SLOT;
                m_off  = m_sp % SLOT;
                if (m_off >= BC) begin
                    exp_an = ~(4'b0001 << m_slot);
                    m_nib  = 4'((m_disp >> (4 * m_slot)) & 16'hF);
                    if (lz_suppress && m_slot > 0 && (m_disp >> (4 * m_slot)) == 16'h0)
                        exp_seg = 7'h7F;
                    else
                        exp_seg = ~hex_g2a[m_nib];
                    exp_dp = ~m_disp_dp[m_slot];
                    exp_fs = (m_slot == 0) && (m_off == BC);
                end
            end
            if (!enable) m_sp = -1;
            else m_sp = (m_sp < 0) ? 0 : (m_sp + 1) % FRAME;
            if (enable && m_sp == 0) begin
                m_disp    = load ? value : m_shadow;
                m_disp_dp = load ? dp_in : m_shadow_dp;
            end
            if (load) begin
                m_shadow    = value;
                m_shadow_dp = dp_in;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    // scoreboard: every cycle once the model has seen reset
    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_an", an, exp_an);
            chk("model_seg", seg, exp_seg);
            chk("model_dp", dp, exp_dp);
            chk("model_fs", frame_start, exp_fs);
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pins(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                        input logic e_dp);
        chk({name, "_an"}, an, e_an);
        chk({name, "_seg"}, seg, e_seg);
        chk({name, "_dp"}, dp, e_dp);
    endtask

    task automatic wait_fs(input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (frame_start !== 1'b1 && waited < budget);
        chk("frame_start_seen", frame_start, 1'b1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
    endtask

    int w;

    initial begin
        // reset / idle
        for (int i = 0; i < 3; i++) begin
            tick(1);
            pins("reset", 4'hF, 7'h7F, 1'b1);
            chk("reset_fs", frame_start, 1'b0);
        end
        rst = 1'b0;
        tick(1);

        // basic scan of 1A2F
        do_load(16'h1A2F, 4'h0);
        enable = 1'b1;
        wait_fs(10, w);
        chk("enable_latency", w, 3);
        pins("scan_d0", 4'b1110, 7'b0001110, 1'b1);
        tick(5);
        pins("scan_d1", 4'b1101, 7'b0100100, 1'b1);
        tick(5);
        pins("scan_d2", 4'b1011, 7'b0001000, 1'b1);
        tick(5);
        pins("scan_d3", 4'b0111, 7'b1111001, 1'b1);
        wait_fs(30, w);
        wait_fs(30, w);
        chk("frame_period", w, FRAME);

        // tear-free update loaded during digit 2
        tick(10);
        do_load(16'h1234, 4'h0);
        pins("tear_d2_old", 4'b1011, 7'b0001000, 1'b1);
        tick(5);
        pins("tear_d3_old", 4'b0111, 7'b1111001, 1'b1);
        wait_fs(30, w);
        pins("tear_d0_new", 4'b1110, 7'b0011001, 1'b1);

        // load coinciding with the wrap
        wait_fs(30, w);
        tick(17);
        do_load(16'h00C0, 4'h0);
        wait_fs(30, w);
        chk("coinc_latency", w, 2);
        pins("coinc_d0", 4'b1110, 7'b1000000, 1'b1);
        tick(5);
        pins("coinc_d1", 4'b1101, 7'b1000110, 1'b1);

        // leading-zero suppression
        lz_suppress = 1'b1;
        do_load(16'h0050, 4'b1000);
        wait_fs(30, w);
        wait_fs(30, w);
        pins("lz_d0", 4'b1110, 7'b1000000, 1'b1);
        tick(5);
        pins("lz_d1", 4'b1101, 7'b0010010, 1'b1);
        tick(5);
        pins("lz_d2", 4'b1011, 7'b1111111, 1'b1);
        tick(5);
        pins("lz_d3", 4'b0111, 7'b1111111, 1'b0);
        do_load(16'h0000, 4'h0);
        wait_fs(30, w);
        wait_fs(30, w);
        pins("lz0_d0", 4'b1110, 7'b1000000, 1'b1);
        tick(5);
        pins("lz0_d1", 4'b1101, 7'b1111111, 1'b1);

        // enable drop during digit 2
        wait_fs(30, w);
        tick(10);
        enable = 1'b0;
        tick(1);
        pins("endrop", 4'hF, 7'h7F, 1'b1);
        chk("endrop_fs", frame_start, 1'b0);
        tick(2);
        enable = 1'b1;
        wait_fs(10, w);
        chk("reenable_latency", w, 3);
        pins("reenable_d0", 4'b1110, 7'b1000000, 1'b1);

        // mid-scan reset clears the shadow
        lz_suppress = 1'b0;
        do_load(16'h1A2F, 4'b0101);
        wait_fs(30, w);
        wait_fs(30, w);
        pins("prerst_d0", 4'b1110, 7'b0001110, 1'b0);
        tick(10);
        rst = 1'b1;
        tick(1);
        pins("midrst", 4'hF, 7'h7F, 1'b1);
        chk("midrst_fs", frame_start, 1'b0);
        rst = 1'b0;
        wait_fs(10, w);
        chk("postrst_latency", w, 3);
        pins("postrst_d0", 4'b1110, 7'b1000000, 1'b1);
        tick(5);
        pins("postrst_d1", 4'b1101, 7'b1000000, 1'b1);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
